// File: rtl/reservation_station.sv
// reservation_station
//   Per-FU reservation station. It holds dispatched instructions in a collapsing queue, where
//   entry 0 is the oldest. Pending source operands are captured by tag-matching the CDB
//   broadcasts. Each cycle the oldest fully-ready entry is issued to the functional unit.
//
// Ports
//   clk_i, reset_i          clock; asynchronous active-high reset
//   dispatch_v_i            dispatch request, accepted when rs_ready_o is also high
//   rs_ready_o              at least one free entry (count < RS_ENTRY)
//   dispatch_payload_i      opaque instruction fields
//   dispatch_src{1,2}_*     per-source ready flag, producer tag and operand value
//   cdb_v_i/tag_i/data_i    NUM_CDB broadcast ports, packed with port 0 in the LSBs
//   fu_ready_i              FU can take an instruction this cycle
//   issue_v_o, issue_*      issued instruction, combinational from registered entries
//   mispredict_i            flush every entry and drop a same-cycle dispatch
//   count_o                 number of occupied entries
module reservation_station #(
    parameter int unsigned RS_ENTRY      = 4,
    parameter int unsigned TAG_WIDTH     = 3,
    parameter int unsigned DATA_WIDTH    = 16,
    parameter int unsigned PAYLOAD_WIDTH = 32,
    parameter int unsigned NUM_CDB       = 4
) (
    input  logic                              clk_i,
    input  logic                              reset_i,
    input  logic                              dispatch_v_i,
    output logic                              rs_ready_o,
    input  logic [PAYLOAD_WIDTH-1:0]          dispatch_payload_i,
    input  logic                              dispatch_src1_rdy_i,
    input  logic [TAG_WIDTH-1:0]              dispatch_src1_tag_i,
    input  logic [DATA_WIDTH-1:0]             dispatch_src1_data_i,
    input  logic                              dispatch_src2_rdy_i,
    input  logic [TAG_WIDTH-1:0]              dispatch_src2_tag_i,
    input  logic [DATA_WIDTH-1:0]             dispatch_src2_data_i,
    input  logic [NUM_CDB-1:0]                cdb_v_i,
    input  logic [NUM_CDB*TAG_WIDTH-1:0]      cdb_tag_i,
    input  logic [NUM_CDB*DATA_WIDTH-1:0]     cdb_data_i,
    input  logic                              fu_ready_i,
    output logic                              issue_v_o,
    output logic [PAYLOAD_WIDTH-1:0]          issue_payload_o,
    output logic [DATA_WIDTH-1:0]             issue_src1_data_o,
    output logic [DATA_WIDTH-1:0]             issue_src2_data_o,
    input  logic                              mispredict_i,
    output logic [$clog2(RS_ENTRY+1)-1:0]     count_o
);

    localparam int unsigned CNT_W = $clog2(RS_ENTRY + 1);
    localparam int unsigned IDX_W = $clog2(RS_ENTRY);

    // Entry state
    logic [RS_ENTRY-1:0]      valid_q, valid_d;
    logic [PAYLOAD_WIDTH-1:0] payload_q [RS_ENTRY];
    logic [PAYLOAD_WIDTH-1:0] payload_d [RS_ENTRY];
    logic [RS_ENTRY-1:0]      s1_rdy_q, s1_rdy_d, s2_rdy_q, s2_rdy_d;
    logic [TAG_WIDTH-1:0]     s1_tag_q [RS_ENTRY];
    logic [TAG_WIDTH-1:0]     s1_tag_d [RS_ENTRY];
    logic [TAG_WIDTH-1:0]     s2_tag_q [RS_ENTRY];
    logic [TAG_WIDTH-1:0]     s2_tag_d [RS_ENTRY];
    logic [DATA_WIDTH-1:0]    s1_data_q [RS_ENTRY];
    logic [DATA_WIDTH-1:0]    s1_data_d [RS_ENTRY];
    logic [DATA_WIDTH-1:0]    s2_data_q [RS_ENTRY];
    logic [DATA_WIDTH-1:0]    s2_data_d [RS_ENTRY];
    logic [CNT_W-1:0]         count_q, count_d;

    // Select the oldest ready entry
    logic             cand_found;
    logic [IDX_W-1:0] cand_idx;

    always_comb begin
        cand_found = 1'b0;
        cand_idx   = '0;
        for (int i = int'(RS_ENTRY) - 1; i >= 0; i--) begin
            if (valid_q[i] && s1_rdy_q[i] && s2_rdy_q[i]) begin
                cand_found = 1'b1;
                cand_idx   = IDX_W'(i);
            end
        end
    end

    assign issue_v_o         = cand_found && fu_ready_i && !mispredict_i;
    assign issue_payload_o   = payload_q[cand_idx];
    assign issue_src1_data_o = s1_data_q[cand_idx];
    assign issue_src2_data_o = s2_data_q[cand_idx];
    assign rs_ready_o        = (count_q < CNT_W'(RS_ENTRY));
    assign count_o           = count_q;

    logic accept;
    assign accept = dispatch_v_i && rs_ready_o && !mispredict_i;

    // The write slot is computed after the collapse, so it is one lower when issuing.
    logic [CNT_W-1:0] wr_idx;
    assign wr_idx = count_q - CNT_W'(issue_v_o);

    // Collapse: each slot at or above the issued one takes its upper neighbour.
    // The top slot has no neighbour and becomes empty.
    logic [RS_ENTRY-1:0]      sh_valid, sh_s1_rdy, sh_s2_rdy;
    logic [PAYLOAD_WIDTH-1:0] sh_payload [RS_ENTRY];
    logic [TAG_WIDTH-1:0]     sh_s1_tag  [RS_ENTRY];
    logic [TAG_WIDTH-1:0]     sh_s2_tag  [RS_ENTRY];
    logic [DATA_WIDTH-1:0]    sh_s1_data [RS_ENTRY];
    logic [DATA_WIDTH-1:0]    sh_s2_data [RS_ENTRY];

    for (genvar i = 0; i < RS_ENTRY; i++) begin : g_shift
        localparam int unsigned Up = (i == RS_ENTRY - 1) ? i : i + 1;
        logic take_up;
        assign take_up       = issue_v_o && (cand_idx <= IDX_W'(i));
        assign sh_valid[i]   = take_up ? (valid_q[Up] && (i != RS_ENTRY - 1)) : valid_q[i];
        assign sh_payload[i] = take_up ? payload_q[Up] : payload_q[i];
        assign sh_s1_rdy[i]  = take_up ? s1_rdy_q[Up]  : s1_rdy_q[i];
        assign sh_s1_tag[i]  = take_up ? s1_tag_q[Up]  : s1_tag_q[i];
        assign sh_s1_data[i] = take_up ? s1_data_q[Up] : s1_data_q[i];
        assign sh_s2_rdy[i]  = take_up ? s2_rdy_q[Up]  : s2_rdy_q[i];
        assign sh_s2_tag[i]  = take_up ? s2_tag_q[Up]  : s2_tag_q[i];
        assign sh_s2_data[i] = take_up ? s2_data_q[Up] : s2_data_q[i];
    end

    // Wakeup of one source. The loop runs from the highest port down, so on a duplicate
    // tag the lowest port is the one that wins.
    function automatic logic [DATA_WIDTH:0] wake(
        input logic                          rdy,
        input logic [TAG_WIDTH-1:0]          tag,
        input logic [DATA_WIDTH-1:0]         data,
        input logic [NUM_CDB-1:0]            v,
        input logic [NUM_CDB*TAG_WIDTH-1:0]  tags,
        input logic [NUM_CDB*DATA_WIDTH-1:0] datas
    );
        logic [DATA_WIDTH:0] r;
        r = {rdy, data};
        if (!rdy) begin
            for (int p = int'(NUM_CDB) - 1; p >= 0; p--) begin
                if (v[p] && (tags[p*TAG_WIDTH +: TAG_WIDTH] == tag)) begin
                    r = {1'b1, datas[p*DATA_WIDTH +: DATA_WIDTH]};
                end
            end
        end
        return r;
    endfunction

    always_comb begin
        valid_d  = sh_valid;
        s1_rdy_d = sh_s1_rdy;
        s2_rdy_d = sh_s2_rdy;
        count_d  = count_q - CNT_W'(issue_v_o) + CNT_W'(accept);
        for (int i = 0; i < int'(RS_ENTRY); i++) begin
            payload_d[i] = sh_payload[i];
            s1_tag_d[i]  = sh_s1_tag[i];
            s2_tag_d[i]  = sh_s2_tag[i];
            {s1_rdy_d[i], s1_data_d[i]} =
                wake(sh_s1_rdy[i], sh_s1_tag[i], sh_s1_data[i], cdb_v_i, cdb_tag_i, cdb_data_i);
            {s2_rdy_d[i], s2_data_d[i]} =
                wake(sh_s2_rdy[i], sh_s2_tag[i], sh_s2_data[i], cdb_v_i, cdb_tag_i, cdb_data_i);
            if (accept && (wr_idx == CNT_W'(i))) begin
                valid_d[i]   = 1'b1;
                payload_d[i] = dispatch_payload_i;
                s1_tag_d[i]  = dispatch_src1_tag_i;
                s2_tag_d[i]  = dispatch_src2_tag_i;
                {s1_rdy_d[i], s1_data_d[i]} = wake(dispatch_src1_rdy_i, dispatch_src1_tag_i,
                    dispatch_src1_data_i, cdb_v_i, cdb_tag_i, cdb_data_i);
                {s2_rdy_d[i], s2_data_d[i]} = wake(dispatch_src2_rdy_i, dispatch_src2_tag_i,
                    dispatch_src2_data_i, cdb_v_i, cdb_tag_i, cdb_data_i);
            end
        end
        if (mispredict_i) begin
            valid_d = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            valid_q <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    // Payload, tags and operands are qualified by valid_q and need no reset.
    always_ff @(posedge clk_i) begin
        payload_q <= payload_d;
        s1_rdy_q  <= s1_rdy_d;
        s2_rdy_q  <= s2_rdy_d;
        s1_tag_q  <= s1_tag_d;
        s2_tag_q  <= s2_tag_d;
        s1_data_q <= s1_data_d;
        s2_data_q <= s2_data_d;
    end

    // Two valid CDB ports carrying the same tag is a protocol error.
    logic dup_cdb;

    always_comb begin
        dup_cdb = 1'b0;
        for (int p = 0; p < int'(NUM_CDB); p++) begin
            for (int q = p + 1; q < int'(NUM_CDB); q++) begin
                if (cdb_v_i[p] && cdb_v_i[q] &&
                    (cdb_tag_i[p*TAG_WIDTH +: TAG_WIDTH] == cdb_tag_i[q*TAG_WIDTH +: TAG_WIDTH])) begin
                    dup_cdb = 1'b1;
                end
            end
        end
    end

    a_no_dup_cdb: assert property (@(posedge clk_i) disable iff (reset_i) !dup_cdb);

endmodule
